add32_seq_ctrl: RTL and testbench
=================================

# add32_seq_ctrl

Multi-cycle 32-bit adder controller that computes `a + b + cin` by sequencing a single shared 8-bit ripple-carry slice over successive byte lanes. It replaces a full-width combinational adder where area matters more than latency. Ready/valid handshakes on input and output let it sit between a producer and a consumer in the lab datapath. One operation is in flight at a time.

## Interface
Parameters:
- `W`, 32, operand and result width; must be a multiple of `SLICE`.
- `SLICE`, 8, width of the shared adder slice; the lane count is `N = W/SLICE` (4 by default).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operands `a`, `b` and `cin` are valid.
- `in_ready`  out  1  the controller can accept operands.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry-in to lane 0.
- `out_valid`  out  1  the result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `sum`  out  W  the result, `(a+b+cin) mod 2^W`.
- `cout`  out  1  carry out of bit W-1.
- `ovf`  out  1  two's-complement signed overflow.
- `busy`  out  1  the controller is in the BUSY state.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, the controller captures `a`, `b` and `cin` into operand registers.
  - Lane index `idx` is set to 0, the carry register is set to `cin`, and the FSM moves to BUSY.
- BUSY, each cycle:
  - The slice adds `a_r[idx*SLICE +: SLICE]`, `b_r[...]` and the carry register.
  - The slice result is written into `sum_r[idx*SLICE +: SLICE]`, and the carry register takes the slice carry-out.
  - At `idx == N-1`, the controller registers `cout` from the slice carry-out, computes `ovf = (a_r[W-1] == b_r[W-1]) & (sum bit W-1 != a_r[W-1])` and moves to DONE.
  - Otherwise `idx` increments.
- DONE:
  - `out_valid` = 1.
  - `sum`, `cout` and `ovf` stay stable until `out_valid & out_ready`, and then the FSM returns to IDLE.
- `in_ready` is 1 only in IDLE. The controller ignores operand and `cin` inputs outside the accepting handshake.
- `busy` is 1 in BUSY only.
- `sum`, `cout` and `ovf` are registered outputs. They keep the last result after returning to IDLE and are overwritten only by the next operation.
- Reset asserted at any time (IDLE, mid-BUSY or DONE) immediately clears everything:
  - FSM returns to IDLE, `idx` = 0, carry register = 0.
  - `sum` = 0, `cout` = 0, `ovf` = 0, `out_valid` = 0.
  - A partial result is discarded and never presented.
- All arithmetic is unsigned modulo 2^W. `cout` is the true carry out of the full W-bit add, identical to a combinational W-bit adder.

## Timing
- Reset values:
  - `in_ready` = 1 (IDLE).
  - `out_valid` = 0, `busy` = 0.
  - `sum` = 0, `cout` = 0, `ovf` = 0.
- Accept at edge E0 → BUSY during cycles E0..E0+N-1 (lane k computed in the cycle ending at edge E0+k+1).
- `out_valid` rises after edge E0+N, which is 4 cycles for default parameters.
- Output handshake at edge E1 → `in_ready` = 1 in the following cycle.
- The earliest next accept is edge E1+1, so minimum throughput is one result per N+2 cycles.
- `in_ready` and `out_valid` are never 1 in the same cycle.
- Holding `out_ready` = 0 stalls indefinitely in DONE with outputs held.
- `out_ready` asserted before DONE has no effect.
- Every slice operation uses the carry registered from the previous lane. The only combinational path per cycle is one SLICE-bit ripple.

## Test plan
- Reset release, then `a`=0x000000FF, `b`=0x00000001, `cin`=0 → after 4 cycles `out_valid`=1, `sum`=0x00000100, `cout`=0, `ovf`=0.
- `a`=0xFFFFFFFF, `b`=0x00000000, `cin`=1 → `sum`=0x00000000, `cout`=1, `ovf`=0; this exercises the full carry ripple through all 4 lanes.
- `a`=0x7FFFFFFF, `b`=0x00000001, `cin`=0 → `sum`=0x80000000, `cout`=0, `ovf`=1. Then `a`=0x80000000, `b`=0x80000000, `cin`=0 → `sum`=0x00000000, `cout`=1, `ovf`=1.
- `a`=0x12345678, `b`=0x11111111, `cin`=1, with `out_ready` held 0 for 5 cycles in DONE:
  - `sum`=0x2345678A is held stable and `in_ready` stays 0.
  - `in_valid` pulses with other operands during BUSY/DONE are ignored.
  - After the handshake, `in_ready`=1 the next cycle.
- Drop `rst_n` during BUSY lane 2 → `out_valid`, `sum`, `cout`, `ovf` and `busy` go to 0 asynchronously. After release, `in_ready`=1 and a fresh 0x00000003+0x00000004 gives 0x00000007.
- Random regression: 1000 random `a`/`b`/`cin` values with random `in_valid`/`out_ready` gaps → every `sum`/`cout`/`ovf` matches the 33-bit reference model, and the accept-to-`out_valid` latency is exactly 4.

Source files
------------

// File: rtl/add32_seq_ctrl_if.sv
// add32_seq_ctrl_if: operand/result ready-valid bundle
// for the byte-serial adder controller.
interface add32_seq_ctrl_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf,
    output busy
  );
endinterface

// File: rtl/add32_seq_ctrl.sv
// add32_seq_ctrl: W-bit a+b+cin computed over N cycles
// by one shared SLICE-bit ripple adder.
module add32_seq_ctrl #(
  parameter int W     = 32,
  parameter int SLICE = 8
) (
  input logic             clk,
  input logic             rst_n,
  add32_seq_ctrl_if.slave bus
);
  localparam int N  = W / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IW-1:0]    r_idx;

  logic [SLICE-1:0] w_a_lane;
  logic [SLICE-1:0] w_b_lane;
  logic [SLICE:0]   w_slice;
  logic             w_accept;
  logic             w_last;

  assign w_a_lane = r_a[r_idx*SLICE +: SLICE];
  assign w_b_lane = r_b[r_idx*SLICE +: SLICE];
  assign w_slice  = {1'b0, w_a_lane}
                  + {1'b0, w_b_lane}
                  + {{SLICE{1'b0}}, r_carry};

  assign w_last   = (r_idx == IW'(N - 1));
  assign w_accept = (r_state == S_IDLE)
                  & bus.in_valid;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_BUSY);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: accept, walk the lanes, hold until drained
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // operand capture and one lane of ripple per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_idx   <= '0;
    end else if (r_state == S_BUSY) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_slice[SLICE-1:0];
      r_carry <= w_slice[SLICE];
      if (w_last) begin
        r_cout <= w_slice[SLICE];
        r_ovf  <= (r_a[W-1] == r_b[W-1])
                & (w_slice[SLICE-1] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_add32_seq_ctrl.sv
// tb_add32_seq_ctrl: scoreboard bench for the byte-serial
// adder, checked against a 33-bit / signed arithmetic model.
module tb_add32_seq_ctrl;
  localparam int W = 32;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  add32_seq_ctrl_if #(.W(W)) bus ();

  add32_seq_ctrl #(
    .W     (W),
    .SLICE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           e0;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   hs_prev  = 0;
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  int   rdy_mode = 0;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, req);
    end
  endfunction

  function automatic exp_t model(logic [W-1:0] a,
                                 logic [W-1:0] b,
                                 logic c, int e0);
    exp_t   e;
    longint u;
    longint s;
    u = longint'({32'd0, a}) + longint'({32'd0, b})
      + longint'(c);
    s = longint'($signed(a)) + longint'($signed(b))
      + longint'(c);
    e.sum  = u[W-1:0];
    e.cout = u[W];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.e0   = e0;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  always @(posedge clk) edges <= edges + 1;

  // input side: every accepted operand set predicts a result
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a, bus.b, bus.cin,
                            edges + 1));
  end

  // output side: pop on out_valid rise, hold while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 0;
      hs_prev  = 0;
    end else begin
      if (hs_prev)
        chk("ready_after_hs", bus.in_ready, 1);
      hs_prev = 0;
      if (bus.out_valid) begin
        chk("valid_ready_excl", bus.in_ready, 0);
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: sum 0x%0h, none pending",
                     bus.sum);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
            chk("latency", edges - cur.e0, N);
          end
        end
        if (have_cur) begin
          chk("sum",  bus.sum,  cur.sum);
          chk("cout", bus.cout, cur.cout);
          chk("ovf",  bus.ovf,  cur.ovf);
          chk("busy_in_done", bus.busy, 0);
        end
        if (bus.out_ready) begin
          have_cur = 0;
          hs_prev  = 1;
        end
      end
    end
  end

  // consumer: always ready, held off, or random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic c);
    int n;
    n = 0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready 0 for %0d cycles, need 1",
                 n);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || have_cur || !bus.in_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: pending %0d, need 0",
                 exp_q.size());
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: run did not finish, need finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_sum",       bus.sum,       0);
    chk("rst_cout",      bus.cout,      0);
    chk("rst_ovf",       bus.ovf,       0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    drain();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b1);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      bus.a   = $urandom;
      bus.b   = $urandom;
      bus.cin = 1'($urandom_range(0, 1));
    end
    chk("stall_reached_done", bus.out_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_sum", bus.sum, 32'h2345_678A);
    end
    bus.in_valid = 1'b0;
    rdy_mode     = 0;
    drain();

    rdy_mode = 0;
    send(32'hAAAA_5555, 32'h1111_1111, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy",      bus.busy,      0);
    chk("arst_sum",       bus.sum,       0);
    chk("arst_cout",      bus.cout,      0);
    chk("arst_ovf",       bus.ovf,       0);
    chk("arst_in_ready",  bus.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0000_0003, 32'h0000_0004, 1'b0);
    drain();
    chk("post_rst_sum", bus.sum, 32'h0000_0007);

    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
